// File: rtl/mux4_mux8.sv
// mux4_mux8 -- bit-sliced 8:1 and 4:1 multiplexers built as 2:1 trees,
// each with an optional registered copy of its result.
//
// Ports
//   clk     rising-edge clock, used only by the output registers
//   reset   asynchronous active-high clear of out_q / out4_q
//   in      8:1 data, slot k at in[k*DW +: DW]
//   sel     8:1 select (sel[2] is the MSB)
//   out     combinational 8:1 result
//   i00..i11  4:1 data inputs
//   sel0    4:1 select LSB
//   sel1    4:1 select MSB
//   out4    combinational 4:1 result
//   en      load enable for both output registers
//   out_q   registered out
//   out4_q  registered out4
module mux4_mux8 #(
    parameter int unsigned DW = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [8*DW-1:0] in,
    input  logic [2:0]      sel,
    output logic [DW-1:0]   out,
    input  logic [DW-1:0]   i00,
    input  logic [DW-1:0]   i01,
    input  logic [DW-1:0]   i10,
    input  logic [DW-1:0]   i11,
    input  logic            sel0,
    input  logic            sel1,
    output logic [DW-1:0]   out4,
    input  logic            en,
    output logic [DW-1:0]   out_q,
    output logic [DW-1:0]   out4_q
);

    // 8:1 tree: level 1 resolved by sel[0], level 2 by sel[1], root by sel[2].
    // A 2:1 ternary stage only forwards the selected leg, so an unknown on an
    // unselected input never reaches the output.
    logic [DW-1:0] lvl1 [4];
    logic [DW-1:0] lvl2 [2];

    for (genvar k = 0; k < 4; k++) begin : g_lvl1
        assign lvl1[k] = sel[0] ? in[(2*k+1)*DW +: DW] : in[(2*k)*DW +: DW];
    end

    for (genvar k = 0; k < 2; k++) begin : g_lvl2
        assign lvl2[k] = sel[1] ? lvl1[2*k+1] : lvl1[2*k];
    end

    assign out = sel[2] ? lvl2[1] : lvl2[0];

    // 4:1 tree: sel0 picks within each pair, sel1 picks the pair.
    logic [DW-1:0] pair_lo;
    logic [DW-1:0] pair_hi;

    assign pair_lo = sel0 ? i01 : i00;
    assign pair_hi = sel0 ? i11 : i10;
    assign out4    = sel1 ? pair_hi : pair_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            out4_q <= '0;
        end else if (en) begin
            out_q  <= out;
            out4_q <= out4;
        end
    end

endmodule

// File: tb/tb_mux4_mux8.sv
`timescale 1ns/1ps
// tb_mux4_mux8 -- directed bench for mux4_mux8: 8:1 and 4:1 sweeps,
// register enable/hold, asynchronous reset, DW=4 instance and a 32:1
// mux assembled from five instances.
module tb_mux4_mux8;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DW=1 device under test
    logic       reset;
    logic [7:0] in;
    logic [2:0] sel;
    logic       out;
    logic       i00, i01, i10, i11;
    logic       sel0, sel1;
    logic       out4;
    logic       en;
    logic       out_q, out4_q;

    mux4_mux8 #(.DW(1)) dut (
        .clk(clk), .reset(reset), .in(in), .sel(sel), .out(out),
        .i00(i00), .i01(i01), .i10(i10), .i11(i11),
        .sel0(sel0), .sel1(sel1), .out4(out4),
        .en(en), .out_q(out_q), .out4_q(out4_q)
    );

    // DW=4 instance
    logic [31:0] w_in;
    logic [2:0]  w_sel;
    logic [3:0]  w_out, w_out4, w_out_q, w_out4_q;
    logic        w_sel0, w_sel1;

    mux4_mux8 #(.DW(4)) dut_w (
        .clk(clk), .reset(reset), .in(w_in), .sel(w_sel), .out(w_out),
        .i00(4'hA), .i01(4'hB), .i10(4'hC), .i11(4'hD),
        .sel0(w_sel0), .sel1(w_sel1), .out4(w_out4),
        .en(1'b0), .out_q(w_out_q), .out4_q(w_out4_q)
    );

    // 32:1 assembly: four 8:1 slices feeding one 4:1 stage
    logic [31:0] data32;
    logic [4:0]  j;
    logic [3:0]  slice;
    logic [3:0]  s_out4, s_q, s_q4;
    logic        m32, m_out, m_q, m_q4;

    for (genvar k = 0; k < 4; k++) begin : g_slice
        mux4_mux8 #(.DW(1)) u8 (
            .clk(clk), .reset(reset), .in(data32[k*8 +: 8]), .sel(j[2:0]),
            .out(slice[k]),
            .i00(1'b0), .i01(1'b0), .i10(1'b0), .i11(1'b0),
            .sel0(1'b0), .sel1(1'b0), .out4(s_out4[k]),
            .en(1'b0), .out_q(s_q[k]), .out4_q(s_q4[k])
        );
    end

    mux4_mux8 #(.DW(1)) u4 (
        .clk(clk), .reset(reset), .in(8'h00), .sel(3'd0), .out(m_out),
        .i00(slice[0]), .i01(slice[1]), .i10(slice[2]), .i11(slice[3]),
        .sel0(j[3]), .sel1(j[4]), .out4(m32),
        .en(1'b0), .out_q(m_q), .out4_q(m_q4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp8 [8];
    logic [3:0] exp4 [4];

    initial begin
        // 8:1 expectations for in=8'hEA, sel 0..7
        exp8 = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1};
        exp4 = '{4'd0, 4'd1, 4'd1, 4'd0};

        reset = 1'b1; en = 1'b0; in = 8'hEA; sel = 3'd0;
        i00 = 1'b0; i01 = 1'b1; i10 = 1'b1; i11 = 1'b0; sel0 = 1'b0; sel1 = 1'b0;
        w_in = 32'h7654_3210; w_sel = 3'd5; w_sel0 = 1'b1; w_sel1 = 1'b1;
        data32 = 32'b01101101001101011001100011101010; j = 5'd0;
        #2;
        check("reset_out_q", {31'd0, out_q}, 32'd0);
        check("reset_out4_q", {31'd0, out4_q}, 32'd0);

        // reset held across an edge: registers stay clear, comb path live
        en = 1'b1; sel = 3'd1; sel0 = 1'b1;
        tick();
        check("reset_hold_q", {31'd0, out_q}, 32'd0);
        check("reset_comb_out", {31'd0, out}, 32'd1);
        @(negedge clk);
        reset = 1'b0; en = 1'b0;

        // 8:1 sweep
        for (int unsigned s = 0; s < 8; s++) begin
            sel = s[2:0];
            #1;
            check($sformatf("mux8_sel%0d", s), {31'd0, out}, {24'd0, exp8[s]});
        end

        // 4:1 sweep
        for (int unsigned s = 0; s < 4; s++) begin
            {sel1, sel0} = s[1:0];
            #1;
            check($sformatf("mux4_sel%0d", s), {31'd0, out4}, {28'd0, exp4[s]});
        end

        // unselected inputs must not disturb the selected result
        sel = 3'd2; in = 8'h04;
        #1;
        check("unsel_base", {31'd0, out}, 32'd1);
        in = 8'hFB;
        #1;
        check("unsel_flip", {31'd0, out}, 32'd0);

        // load then hold
        @(negedge clk);
        en = 1'b1; in = 8'hEA; sel = 3'd1; {sel1, sel0} = 2'b01;
        tick();
        check("load_out_q", {31'd0, out_q}, 32'd1);
        check("load_out4_q", {31'd0, out4_q}, 32'd1);
        @(negedge clk);
        en = 1'b0; sel = 3'd0; {sel1, sel0} = 2'b00;
        tick();
        check("hold_out_q", {31'd0, out_q}, 32'd1);
        check("hold_out4_q", {31'd0, out4_q}, 32'd1);
        check("hold_comb_out", {31'd0, out}, 32'd0);

        // asynchronous reset mid-cycle
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_out_q", {31'd0, out_q}, 32'd0);
        check("async_out4_q", {31'd0, out4_q}, 32'd0);
        @(negedge clk);
        reset = 1'b0; en = 1'b1; sel = 3'd1;
        #1;
        check("release_pre_edge", {31'd0, out_q}, 32'd0);
        tick();
        check("release_load", {31'd0, out_q}, 32'd1);

        // DW=4
        check("w_mux8", {28'd0, w_out}, 32'h5);
        check("w_mux4", {28'd0, w_out4}, 32'hD);
        w_sel = 3'd7; w_sel0 = 1'b0; w_sel1 = 1'b0;
        #1;
        check("w_mux8_top", {28'd0, w_out}, 32'h7);
        check("w_mux4_low", {28'd0, w_out4}, 32'hA);

        // 32:1 sweep
        for (int unsigned s = 0; s < 32; s++) begin
            j = s[4:0];
            #1.0;
            check($sformatf("mux32_j%0d", s), {31'd0, m32}, {31'd0, data32[s]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
